// File: rtl/config_chain_tile.sv
// Configuration tile with a segmented serial shadow chain.
// Bits are shifted into NUM_SEG shadow segments (any of which can be bypassed),
// and on commit the frame length and parity are checked before the shadow is
// copied into the active configuration. Tiles daisy-chain through cfg_in/cfg_out.
module config_chain_tile #(
   parameter int NUM_SEG = 2,
   parameter int SEG_W   = 7,
   parameter int CNT_W   = $clog2(NUM_SEG*SEG_W+1)+1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_in,
   input  logic                     cfg_en,
   input  logic                     cfg_commit,
   input  logic                     cfg_parity,
   input  logic [NUM_SEG-1:0]       seg_bypass,
   output logic                     cfg_out,
   output logic [NUM_SEG*SEG_W-1:0] active_cfg,
   output logic                     busy,
   output logic                     cfg_done,
   output logic                     cfg_err
);

   localparam int TOT_W = NUM_SEG*SEG_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [TOT_W-1:0]   shadow_q, shadow_d;
   logic [TOT_W-1:0]   active_q, active_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               par_q, par_d;
   logic [NUM_SEG-1:0] byp_q, byp_d;
   logic               exp_par_q, exp_par_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               shift_ok;
   logic               chain_out;
   logic [CNT_W-1:0]   exp_len;
   logic               frame_ok;

   // Shifting and committing are both ignored while the frame is being checked.
   assign shift_ok = cfg_en && (state_q != CHECK);

   // Shadow chain: walk the segments in order, feeding each live segment from the previous live MSB.
   always_comb begin
      logic src;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      shadow_d = shadow_q;
      src      = cfg_in;
      for (int k = 0; k < NUM_SEG; k++) begin
         if (!seg_bypass[k]) begin
            if (shift_ok) begin
               shadow_d[k*SEG_W +: SEG_W] = {shadow_q[k*SEG_W +: SEG_W-1], src};
            end
            src = shadow_q[k*SEG_W + SEG_W-1];
         end
      end
      chain_out = src;
   end

   // Frame check: the expected length counts only the segments live at commit time.
   always_comb begin
      exp_len = '0;
      for (int k = 0; k < NUM_SEG; k++) begin
         if (!byp_q[k]) begin
            exp_len = exp_len + CNT_W'(SEG_W);
         end
      end
      frame_ok = (cnt_q == exp_len) && (par_q == exp_par_q);
   end

   // Control FSM with counter, parity accumulator, apply and status flags.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      par_d     = par_q;
      byp_d     = byp_q;
      exp_par_d = exp_par_q;
      active_d  = active_q;
      done_d    = 1'b0;
      err_d     = err_q;
      case (state_q)
         CHECK: begin
            state_d = IDLE;
            cnt_d   = '0;
            par_d   = 1'b0;
            if (frame_ok) begin
               for (int k = 0; k < NUM_SEG; k++) begin
                  if (!byp_q[k]) begin
                     active_d[k*SEG_W +: SEG_W] = shadow_q[k*SEG_W +: SEG_W];
                  end
               end
               done_d = 1'b1;
               err_d  = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end
         default: begin
            if (cfg_en) begin
               // Saturate so an overlong frame can never wrap back to a legal length.
               if (!(&cnt_q)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               par_d = par_q ^ cfg_in;
               err_d = 1'b0;
               if (state_q == IDLE) begin
                  state_d = LOAD;
               end
            end
            if (cfg_commit) begin
               state_d   = CHECK;
               byp_d     = seg_bypass;
               exp_par_d = cfg_parity;
            end
         end
      endcase
   end

   // State registers; reset aborts any frame and clears the applied configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         active_q  <= '0;
         cnt_q     <= '0;
         par_q     <= 1'b0;
         byp_q     <= '0;
         exp_par_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         par_q     <= par_d;
         byp_q     <= byp_d;
         exp_par_q <= exp_par_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign cfg_out    = chain_out;
   assign active_cfg = active_q;
   assign busy       = (state_q == CHECK);
   assign cfg_done   = done_q;
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_config_chain_tile.sv
// Bench for config_chain_tile: directed frames with literal expectations plus
// randomized frames, all compared every cycle against a frame-level model.
module tb_config_chain_tile;

   localparam int NUM_SEG = 2;
   localparam int SEG_W   = 7;
   localparam int W       = NUM_SEG*SEG_W;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_in = 1'b0;
   logic               cfg_en = 1'b0;
   logic               cfg_commit = 1'b0;
   logic               cfg_parity = 1'b0;
   logic [NUM_SEG-1:0] seg_bypass = '0;
   logic               cfg_out;
   logic [W-1:0]       active_cfg;
   logic               busy;
   logic               cfg_done;
   logic               cfg_err;

   int checks = 0;
   int errors = 0;

   config_chain_tile #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_in     (cfg_in),
      .cfg_en     (cfg_en),
      .cfg_commit (cfg_commit),
      .cfg_parity (cfg_parity),
      .seg_bypass (seg_bypass),
      .cfg_out    (cfg_out),
      .active_cfg (active_cfg),
      .busy       (busy),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Shadow kept per segment; a shift treats the live segments as one long
   // shift register. The frame is a plain bit queue; length/parity come from it.
   bit [SEG_W-1:0]   m_seg [NUM_SEG];
   bit [W-1:0]       m_active;
   bit               m_frame[$];
   bit               m_check, m_done, m_err;
   bit [NUM_SEG-1:0] m_byp;
   bit               m_par;

   function automatic void model_shift(input bit b, input bit [NUM_SEG-1:0] byp);
      bit chain[$];
      int idx;
      for (int k = 0; k < NUM_SEG; k++)
         if (!byp[k]) for (int i = 0; i < SEG_W; i++) chain.push_back(m_seg[k][i]);
      chain.push_front(b);
      void'(chain.pop_back());
      idx = 0;
      for (int k = 0; k < NUM_SEG; k++)
         if (!byp[k]) for (int i = 0; i < SEG_W; i++) begin
            m_seg[k][i] = chain[idx];
            idx++;
         end
   endfunction

   function automatic bit model_out(input bit b, input bit [NUM_SEG-1:0] byp);
      bit chain[$];
      for (int k = 0; k < NUM_SEG; k++)
         if (!byp[k]) for (int i = 0; i < SEG_W; i++) chain.push_back(m_seg[k][i]);
      if (chain.size() == 0) return b;
      return chain[$];
   endfunction

   function automatic bit model_pass();
      int need;
      bit x;
      need = 0;
      x = 1'b0;
      for (int k = 0; k < NUM_SEG; k++) if (!m_byp[k]) need += SEG_W;
      foreach (m_frame[i]) x ^= m_frame[i];
      return (m_frame.size() == need) && (x == m_par);
   endfunction

   // Model update on each clock edge, using the inputs held before the edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_SEG; k++) m_seg[k] = '0;
         m_active = '0;
         m_frame.delete();
         m_check = 0; m_done = 0; m_err = 0; m_byp = '0; m_par = 0;
      end else if (m_check) begin
         if (model_pass()) begin
            for (int k = 0; k < NUM_SEG; k++)
               if (!m_byp[k]) m_active[k*SEG_W +: SEG_W] = m_seg[k];
            m_done = 1; m_err = 0;
         end else begin
            m_done = 0; m_err = 1;
         end
         m_frame.delete();
         m_check = 0;
      end else begin
         m_done = 0;
         if (cfg_en) begin
            model_shift(cfg_in, seg_bypass);
            m_frame.push_back(cfg_in);
            m_err = 0;
         end
         if (cfg_commit) begin
            m_check = 1; m_byp = seg_bypass; m_par = cfg_parity;
         end
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy",       32'(busy),       32'(m_check));
         check("cfg_done",   32'(cfg_done),   32'(m_done));
         check("cfg_err",    32'(cfg_err),    32'(m_err));
         check("active_cfg", 32'(active_cfg), 32'(m_active));
         check("cfg_out",    32'(cfg_out),    32'(model_out(cfg_in, seg_bypass)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] v, input int n, input bit commit_last);
      for (int i = n-1; i >= 0; i--) begin
         cfg_en     = 1'b1;
         cfg_in     = v[i];
         cfg_commit = commit_last && (i == 0);
         tick();
      end
      cfg_en     = 1'b0;
      cfg_commit = 1'b0;
   endtask

   task automatic commit(input bit p);
      cfg_commit = 1'b1;
      cfg_parity = p;
      tick();
      cfg_commit = 1'b0;
   endtask

   initial begin
      logic [13:0] v14;
      logic [6:0]  v7;

      // Reset held from time zero.
      repeat (3) tick();
      check("rst_active", 32'(active_cfg), 32'h0);
      check("rst_flags",  32'({busy, cfg_done, cfg_err, cfg_out}), 32'h0);
      rst = 1'b0;
      tick();
      check("post_rst_out",  32'(cfg_out), 32'h0);
      check("post_rst_busy", 32'(busy),    32'h0);

      // Good frame 0x2A5C, odd number of ones -> parity 1.
      v14 = 14'h2A5C;
      send(32'(v14), 14, 1'b0);
      commit(1'b1);
      check("good_busy_t1", 32'(busy),     32'h1);
      check("good_done_t1", 32'(cfg_done), 32'h0);
      tick();
      check("good_active", 32'(active_cfg), 32'h2A5C);
      check("good_done",   32'(cfg_done),   32'h1);
      check("good_err",    32'(cfg_err),    32'h0);
      check("good_out",    32'(cfg_out),    32'h1);
      tick();
      check("good_done_pulse", 32'(cfg_done), 32'h0);

      // Short frame: 13 bits.
      v14 = 14'h1234;
      send(32'(v14), 13, 1'b0);
      commit(^v14[12:0]);
      tick();
      check("short_err",    32'(cfg_err),    32'h1);
      check("short_done",   32'(cfg_done),   32'h0);
      check("short_active", 32'(active_cfg), 32'h2A5C);
      send(32'h1, 1, 1'b0);
      check("err_cleared", 32'(cfg_err), 32'h0);
      commit(1'b1);
      tick();
      check("one_bit_err", 32'(cfg_err), 32'h1);

      // Bad parity on a full-length frame.
      v14 = 14'h0F0F;
      send(32'(v14), 14, 1'b0);
      commit(~(^v14));
      tick();
      check("parity_err",    32'(cfg_err),    32'h1);
      check("parity_active", 32'(active_cfg), 32'h2A5C);

      // Segment 1 bypassed: 7-bit frame updates segment 0 only.
      seg_bypass = 2'b10;
      v7 = 7'h55;
      send(32'(v7), 7, 1'b0);
      commit(^v7);
      tick();
      check("byp_active", 32'(active_cfg), 32'h2A55);
      check("byp_done",   32'(cfg_done),   32'h1);
      check("byp_out",    32'(cfg_out),    32'h1);

      // Shift and commit in the same cycle; shifts during CHECK are ignored.
      seg_bypass = 2'b00;
      v14 = 14'h1ABC;
      cfg_parity = ^v14;
      send(32'(v14), 14, 1'b1);
      cfg_en = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1;
      check("sim_busy", 32'(busy), 32'h1);
      tick();
      cfg_en = 1'b0; cfg_commit = 1'b0;
      check("sim_done",   32'(cfg_done),   32'h1);
      check("sim_active", 32'(active_cfg), 32'h1ABC);
      send(32'h1, 1, 1'b0);
      commit(1'b1);
      tick();
      check("sim_next_err", 32'(cfg_err), 32'h1);

      // All segments bypassed: zero-bit frame passes, cfg_out follows cfg_in.
      seg_bypass = 2'b11;
      commit(1'b0);
      tick();
      check("triv_done",   32'(cfg_done),   32'h1);
      check("triv_err",    32'(cfg_err),    32'h0);
      check("triv_active", 32'(active_cfg), 32'h1ABC);
      cfg_in = 1'b1; #1;
      check("thru_out_1", 32'(cfg_out), 32'h1);
      cfg_in = 1'b0; #1;
      check("thru_out_0", 32'(cfg_out), 32'h0);

      // Asynchronous reset mid-cycle.
      seg_bypass = 2'b00;
      send(32'h5, 3, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_active", 32'(active_cfg), 32'h0);
      check("async_flags",  32'({busy, cfg_done, cfg_err, cfg_out}), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      check("async_post_busy", 32'(busy), 32'h0);

      // Randomized frames.
      for (int f = 0; f < 200; f++) begin
         int  need, len, r;
         bit  p, sim, b, bad;
         seg_bypass = 2'($urandom_range(0, 3));
         need = 0;
         for (int k = 0; k < NUM_SEG; k++) if (!seg_bypass[k]) need += SEG_W;
         r = $urandom_range(0, 99);
         if (r < 10)      len = need - 1;
         else if (r < 20) len = need + 1;
         else if (r < 26) len = need + 32;
         else             len = need;
         if (len < 0) len = 0;
         sim = (len > 0) && ($urandom_range(0, 2) == 0);
         bad = ($urandom_range(0, 4) == 0);
         p = 1'b0;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               cfg_en = 1'b0;
               tick();
            end
            b = 1'($urandom);
            p ^= b;
            cfg_en = 1'b1;
            cfg_in = b;
            if (sim && i == len-1) begin
               cfg_commit = 1'b1;
               cfg_parity = p ^ bad;
            end
            if (f % 40 == 17 && i == len/2) begin
               #2 rst = 1'b1;
               #4 rst = 1'b0;
            end
            tick();
         end
         cfg_en = 1'b0;
         if (!sim) begin
            cfg_commit = 1'b1;
            cfg_parity = p ^ bad;
            tick();
         end
         cfg_commit = 1'b0;
         cfg_en     = 1'($urandom);
         cfg_in     = 1'($urandom);
         cfg_commit = 1'($urandom);
         tick();
         cfg_en     = 1'b0;
         cfg_commit = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
